shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one 54-bit logical barrel shifter between two requesters in the FP datapath.
- Requester 0 is the exponent-alignment stage and issues right shifts. Requester 1 is the post-add normaliser and issues left shifts.
- Round-robin arbitration, valid/ready handshake on both request ports, one registered response stage with backpressure.
- Produces the shifted mantissa plus a sticky bit (right shift) or an overflow flag (left shift), tagged with the requester id.

Parameters:
- WIDTH, 54, data width of mantissa operands.
- SHW, 6, shift-amount width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle (when req0_valid=1).
- req0_data  in  WIDTH  operand for requester 0.
- req0_amt  in  SHW  shift amount for requester 0.
- req0_dir  in  1  0 = left, 1 = right.
- req1_valid, req1_ready, req1_data, req1_amt, req1_dir  same meanings for requester 1.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  shifted result.
- rsp_flag  out  1  right shift: OR of all bits shifted out (sticky). Left shift: OR of all bits shifted out (overflow).
- rsp_id  out  1  requester that owns the response.
- busy  out  1  rsp_valid & ~rsp_ready (stall indicator).

Behaviour:
- Reset (async, rst=1): rsp_valid=0, rsp_data=0, rsp_flag=0, rsp_id=0, priority pointer=1.
  - Pointer=1 means requester 0 wins the first tie.
  - Any in-flight response is discarded. req*_ready=0 while rst is high.
- Slot free: out_free = ~rsp_valid | rsp_ready. A new result may be loaded in the same cycle the old one is consumed.
- Grant (combinational from valids and pointer):
  - Only one valid: that requester is granted.
  - Both valid: the requester != pointer is granted.
  - reqN_ready = grantN & out_free. The ready of the non-granted requester is 0.
- Transfer occurs when reqN_valid & reqN_ready. On transfer:
  - Pointer <= N.
  - Response register loads result, flag and id=N. rsp_valid <= 1.
- No transfer and rsp_ready=1: rsp_valid <= 0. Data, flag and id hold their previous values.
- Pointer changes only on a transfer, never on valid-without-ready.
- Latency: exactly 1 cycle from accepting edge to rsp_valid. Sustained throughput is 1 request/cycle while rsp_ready=1.
- Arithmetic:
  - amt >= WIDTH (54..63): result = 0, flag = OR of entire operand.
  - amt = 0: result = operand, flag = 0.
  - Right shift is logical (zero fill from MSB). Left shift zero-fills from LSB.
  - flag is computed on the full operand, before truncation.
- Requester contract: request fields stay stable while valid=1 and ready=0. The block does not check this.
- Response stability: rsp_data, rsp_flag and rsp_id are stable while rsp_valid=1 and rsp_ready=0.
- Starvation bound: a valid requester is granted within 2 free slots.
- rst asserted mid-transfer: accept nothing. After release, the first grant follows the reset pointer.

Decomposition:
- Package shift_pkg:
  - constants MANT_W=54, SHAMT_W=6.
  - enum shift_dir_t {SH_LEFT=0, SH_RIGHT=1}.
  - requester id constants REQ_ALIGN=0, REQ_NORM=1.
- Sub-module shift_core: combinational shift plus flag (data, amt, dir -> result, flag). It holds the single shared shifter instance.
- The arbiter holds only grant logic, pointer and response register.

Test Plan:
- Reset, then req0 only: data=0x20_0000_0000_0001, amt=4, dir=right.
  - Required: req0_ready=1; next cycle rsp_valid=1, rsp_data=0x02_0000_0000_0000, rsp_flag=1, rsp_id=0.
- Both valid every cycle, rsp_ready=1.
  - Required: grants alternate 0,1,0,1 starting with 0; one response per cycle with matching ids.
- Backpressure: rsp_ready=0 for 3 cycles with both requesters valid.
  - Required: rsp_valid held with stable data/flag/id; both readys 0; pointer unchanged.
  - Required: on rsp_ready=1, the next grant goes to the non-pointer requester in that same cycle.
- Boundaries on req1:
  - amt=0, data=0x3 -> rsp_data=0x3, flag=0.
  - Left shift, amt=53, data=0x3 -> rsp_data=bit53 set, flag=1.
  - amt=60, data=0x1 -> rsp_data=0, flag=1.
- Async reset asserted mid-cycle while rsp_valid=1 and requests pending.
  - Required: rsp_valid drops immediately (no clock), readys 0.
  - Required: after deassert with both valid, req0 is granted first.
- Random: 10k random requests with random rsp_ready, checked against a reference model.
  - Required: no lost or duplicated responses; per-requester ordering preserved; starvation bound holds.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shared constants, direction enum and round-robin grant helper for the shift arbiter
package shift_pkg;
  localparam int MANT_W  = 54;
  localparam int SHAMT_W = 6;
  typedef enum logic {
    SH_LEFT  = 1'b0,
    SH_RIGHT = 1'b1
  } shift_dir_t;
  localparam logic REQ_ALIGN = 1'b0;
  localparam logic REQ_NORM  = 1'b1;
  // Returns {grant1, grant0}; on a tie the requester that is not the pointer wins.
  function automatic logic [1:0] rr_grant(input logic v0, input logic v1, input logic ptr);
    return {v1 & (~v0 | (ptr == REQ_ALIGN)), v0 & (~v1 | (ptr == REQ_NORM))};
  endfunction
endpackage

// File: rtl/shift_core.sv
// shift_core: the one shared logical shifter; left shifts reuse the right shifter via bit reversal
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = MANT_W,
  parameter int SHW   = SHAMT_W
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_amt,
  input  shift_dir_t       i_dir,
  output logic [WIDTH-1:0] o_result,
  output logic             o_flag
);
  localparam logic [WIDTH-1:0] ONES = '1;
  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < WIDTH; k++) r[k] = v[WIDTH-1-k];
    return r;
  endfunction
  logic [WIDTH-1:0] w_in;
  logic [WIDTH-1:0] w_sh;
  logic [WIDTH-1:0] w_lost;
  // Amounts at or beyond WIDTH shift everything out, so result and flag fall out naturally.
  always_comb begin
    w_in     = (i_dir == SH_RIGHT) ? i_data : rev(i_data);
    w_sh     = w_in >> i_amt;
    w_lost   = w_in & ~(ONES << i_amt);
    o_result = (i_dir == SH_RIGHT) ? w_sh : rev(w_sh);
    o_flag   = |w_lost;
  end
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one barrel shifter between alignment and normaliser requesters
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int WIDTH = MANT_W,
  parameter int SHW   = SHAMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [SHW-1:0]   req0_amt,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [SHW-1:0]   req1_amt,
  input  logic             req1_dir,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_flag,
  output logic             rsp_id,
  output logic             busy
);
  logic             r_ptr;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_flag;
  logic             r_id;
  logic [1:0]       w_grant;
  logic             w_free;
  logic             w_xfer;
  logic             w_sel;
  logic [WIDTH-1:0] w_data;
  logic [SHW-1:0]   w_amt;
  logic             w_dir;
  logic [WIDTH-1:0] w_result;
  logic             w_flag;
  assign w_free     = ~r_valid | rsp_ready;
  assign w_grant    = rr_grant(req0_valid, req1_valid, r_ptr);
  assign req0_ready = w_grant[0] & w_free & ~rst;
  assign req1_ready = w_grant[1] & w_free & ~rst;
  assign w_xfer     = req0_ready | req1_ready;
  assign w_sel      = w_grant[1] ? REQ_NORM : REQ_ALIGN;
  assign w_data     = w_sel ? req1_data : req0_data;
  assign w_amt      = w_sel ? req1_amt : req0_amt;
  assign w_dir      = w_sel ? req1_dir : req0_dir;
  shift_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
    .i_data  (w_data),
    .i_amt   (w_amt),
    .i_dir   (shift_dir_t'(w_dir)),
    .o_result(w_result),
    .o_flag  (w_flag)
  );
  // Pointer records the last requester served; it moves only on an actual transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= REQ_NORM;
    else if (w_xfer) r_ptr <= w_sel;
  end
  // Response register: load on transfer, otherwise empty it once consumed, keeping payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_flag  <= 1'b0;
      r_id    <= REQ_ALIGN;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_result;
      r_flag  <= w_flag;
      r_id    <= w_sel;
    end else if (rsp_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign rsp_valid = r_valid;
  assign rsp_data  = r_data;
  assign rsp_flag  = r_flag;
  assign rsp_id    = r_id;
  assign busy      = r_valid & ~rsp_ready;
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed vectors plus a randomized scoreboard run for shift_arbiter
module tb_shift_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [53:0] req0_data = '0, req1_data = '0;
  logic [5:0]  req0_amt = '0, req1_amt = '0;
  logic        req0_dir = 1'b0, req1_dir = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [53:0] rsp_data;
  logic        rsp_flag, rsp_id, busy;
  int          n_cmp = 0, n_err = 0;
  logic [55:0] exp_q[$];
  shift_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_dir(req1_dir),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flag(rsp_flag), .rsp_id(rsp_id), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask
  // Bit-by-bit reference: {flag, result}
  function automatic logic [54:0] model(input logic [53:0] d, input logic [5:0] a, input logic dir);
    logic [53:0] r;
    logic        f;
    int          dst;
    r = '0;
    f = 1'b0;
    for (int i = 0; i < 54; i++) begin
      dst = dir ? i - int'(a) : i + int'(a);
      if (dst < 0 || dst > 53) f = f | d[i];
      else r[dst] = d[i];
    end
    return {f, r};
  endfunction
  initial begin
    logic [63:0] t;
    logic [55:0] e;
    logic        free, done0, done1;
    int          acc, cycles, w0, w1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    cyc();
    cyc();
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_flag", rsp_flag, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    rst = 1'b0;
    req1_valid = 1'b0;
    req0_data = 54'h20_0000_0000_0001;
    req0_amt = 6'd4;
    req0_dir = 1'b1;
    #1;
    chk("t1_rdy0", req0_ready, 1);
    cyc();
    req0_valid = 1'b0;
    chk("t1_valid", rsp_valid, 1);
    chk("t1_data", rsp_data, 54'h02_0000_0000_0000);
    chk("t1_flag", rsp_flag, 1);
    chk("t1_id", rsp_id, 0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req0_valid = 1'b1;
    req0_data = 54'h100;
    req0_amt = 6'd1;
    req0_dir = 1'b1;
    req1_valid = 1'b1;
    req1_data = 54'h5;
    req1_amt = 6'd2;
    req1_dir = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_rdy0", req0_ready, 64'(i % 2 == 0));
      chk("alt_rdy1", req1_ready, 64'(i % 2 == 1));
      cyc();
      chk("alt_valid", rsp_valid, 1);
      chk("alt_id", rsp_id, 64'(i % 2));
      chk("alt_data", rsp_data, (i % 2 == 1) ? 64'h14 : 64'h80);
      chk("alt_flag", rsp_flag, 0);
    end
    rsp_ready = 1'b0;
    #1;
    chk("bp_rdy0", req0_ready, 0);
    chk("bp_rdy1", req1_ready, 0);
    chk("bp_busy", busy, 1);
    repeat (3) begin
      cyc();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 64'h14);
      chk("bp_flag", rsp_flag, 0);
      chk("bp_id", rsp_id, 1);
      chk("bp_rdy0", req0_ready, 0);
      chk("bp_rdy1", req1_ready, 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_rdy0", req0_ready, 1);
    chk("bp_rel_rdy1", req1_ready, 0);
    cyc();
    chk("bp_rel_id", rsp_id, 0);
    chk("bp_rel_data", rsp_data, 64'h80);
    req0_valid = 1'b0;
    req1_data = 54'h3;
    req1_amt = 6'd0;
    req1_dir = 1'b1;
    cyc();
    chk("b0_data", rsp_data, 64'h3);
    chk("b0_flag", rsp_flag, 0);
    chk("b0_id", rsp_id, 1);
    req1_amt = 6'd53;
    req1_dir = 1'b0;
    cyc();
    chk("b53_data", rsp_data, 64'h20_0000_0000_0000);
    chk("b53_flag", rsp_flag, 1);
    req1_data = 54'h1;
    req1_amt = 6'd60;
    req1_dir = 1'b1;
    cyc();
    chk("b60_data", rsp_data, 0);
    chk("b60_flag", rsp_flag, 1);
    chk("b60_valid", rsp_valid, 1);
    req0_valid = 1'b1;
    rsp_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", rsp_valid, 0);
    chk("ar_rdy0", req0_ready, 0);
    chk("ar_rdy1", req1_ready, 0);
    cyc();
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("ar_post_rdy0", req0_ready, 1);
    chk("ar_post_rdy1", req1_ready, 0);
    cyc();
    chk("ar_post_id", rsp_id, 0);
    chk("ar_post_valid", rsp_valid, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    acc = 0;
    cycles = 0;
    w0 = 0;
    w1 = 0;
    done0 = 1'b0;
    done1 = 1'b0;
    while (acc < 10000 && cycles < 60000) begin
      if (done0) req0_valid = 1'b0;
      if (done1) req1_valid = 1'b0;
      done0 = 1'b0;
      done1 = 1'b0;
      if (!req0_valid && $urandom_range(3) != 0) begin
        t = {$urandom(), $urandom()};
        req0_data = t[53:0];
        req0_amt = 6'($urandom_range(63));
        req0_dir = 1'($urandom_range(1));
        req0_valid = 1'b1;
      end
      if (!req1_valid && $urandom_range(3) != 0) begin
        t = {$urandom(), $urandom()};
        req1_data = t[53:0];
        req1_amt = 6'($urandom_range(63));
        req1_dir = 1'($urandom_range(1));
        req1_valid = 1'b1;
      end
      rsp_ready = $urandom_range(3) != 0;
      #1;
      if (rsp_valid && rsp_ready) begin
        chk("rand_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rand_id", rsp_id, e[55]);
          chk("rand_flag", rsp_flag, e[54]);
          chk("rand_data", rsp_data, e[53:0]);
        end
      end
      free = !rsp_valid || rsp_ready;
      if (req0_valid) begin
        if (req0_ready) begin
          exp_q.push_back({1'b0, model(req0_data, req0_amt, req0_dir)});
          chk("starve0", 64'(w0 > 1), 0);
          w0 = 0;
          acc++;
          done0 = 1'b1;
        end else if (free) w0++;
      end
      if (req1_valid) begin
        if (req1_ready) begin
          exp_q.push_back({1'b1, model(req1_data, req1_amt, req1_dir)});
          chk("starve1", 64'(w1 > 1), 0);
          w1 = 0;
          acc++;
          done1 = 1'b1;
        end else if (free) w1++;
      end
      cycles++;
      cyc();
    end
    chk("rand_count", 64'(acc >= 10000), 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    if (rsp_valid) begin
      chk("drain_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("drain_id", rsp_id, e[55]);
        chk("drain_flag", rsp_flag, e[54]);
        chk("drain_data", rsp_data, e[53:0]);
      end
    end
    cyc();
    chk("rand_lost", 64'(exp_q.size()), 0);
    chk("drain_valid", rsp_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
